// File: rtl/spi_target_stream.sv
// SPI target (slave) with a configurable word width, mode and bit order, running entirely in the clk domain.
// It provides full-duplex word streams with valid/ready handshakes and reports overrun, underrun and abort events.
module spi_target_stream #(
  parameter int unsigned               DATA_WIDTH  = 8,
  parameter bit                        CPOL        = 1'b0,
  parameter bit                        CPHA        = 1'b0,
  parameter bit                        MSB_FIRST   = 1'b1,
  parameter int unsigned               SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0]     TX_IDLE     = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  rx_overrun,
  output logic                  tx_underrun,
  output logic                  frame_abort,
  output logic                  busy
);

  localparam int unsigned    CW       = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0]  LAST_BIT = CW'(DATA_WIDTH - 1);

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   sclk_s, cs_s, mosi_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync_q <= {SYNC_STAGES{CPOL}};
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= CPOL;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  logic lead_edge, trail_edge, cs_act, cs_fall, cs_rise, sample_edge, shift_edge;

  assign lead_edge   = (sclk_s != sclk_prev_q) && (sclk_prev_q == CPOL);
  assign trail_edge  = (sclk_s != sclk_prev_q) && (sclk_prev_q != CPOL);
  assign cs_act      = !cs_s;
  assign cs_fall     = cs_prev_q && !cs_s;
  assign cs_rise     = !cs_prev_q && cs_s;
  assign sample_edge = cs_act && (CPHA ? trail_edge : lead_edge);
  assign shift_edge  = cs_act && (CPHA ? lead_edge : trail_edge);

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d, tx_shift_q, tx_shift_d;
  logic                  rx_valid_q, rx_valid_d, hold_full_q, hold_full_d, miso_q, miso_d;
  logic                  rx_overrun_q, rx_overrun_d, tx_underrun_q, tx_underrun_d;
  logic                  frame_abort_q, frame_abort_d;
  logic [DATA_WIDTH-1:0] rx_next, tx_word;
  logic                  word_done, tx_load;

  always_comb begin
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    tx_shift_d    = tx_shift_q;
    miso_d        = miso_q;
    rx_overrun_d  = 1'b0;
    tx_underrun_d = 1'b0;
    frame_abort_d = 1'b0;

    rx_next   = MSB_FIRST ? {rx_shift_q[DATA_WIDTH-2:0], mosi_s}
                          : {mosi_s, rx_shift_q[DATA_WIDTH-1:1]};
    word_done = sample_edge && (bit_cnt_q == LAST_BIT);
    tx_word   = hold_full_q ? hold_q : TX_IDLE;
    // Mode 0/2 preloads on cs fall and at each word-boundary shift edge; mode 1/3 on the first leading edge of a word.
    tx_load   = CPHA ? (shift_edge && bit_cnt_q == '0)
                     : (cs_fall || (shift_edge && bit_cnt_q == '0));

    if (sample_edge) begin
      rx_shift_d = rx_next;
      bit_cnt_d  = word_done ? '0 : bit_cnt_q + 1'b1;
    end

    if (!cs_act) begin
      bit_cnt_d = '0;
      if (cs_rise && bit_cnt_q != '0) begin
        frame_abort_d = 1'b1;
        rx_shift_d    = '0;
      end
    end

    if (word_done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = rx_next;
        rx_valid_d = 1'b1;
      end else begin
        rx_overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    if (tx_load) begin
      miso_d        = first_bit(tx_word);
      tx_shift_d    = advance(tx_word);
      hold_full_d   = 1'b0;
      tx_underrun_d = !hold_full_q;
    end else if (shift_edge) begin
      miso_d     = first_bit(tx_shift_q);
      tx_shift_d = advance(tx_shift_q);
    end

    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    if (!cs_act) miso_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      tx_shift_q    <= '0;
      miso_q        <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      tx_shift_q    <= tx_shift_d;
      miso_q        <= miso_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_underrun_q <= tx_underrun_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  assign miso        = miso_q;
  assign tx_ready    = !hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_overrun  = rx_overrun_q;
  assign tx_underrun = tx_underrun_q;
  assign frame_abort = frame_abort_q;
  assign busy        = cs_act;

endmodule

// File: tb/tb_spi_target_stream.sv
// Directed bench for spi_target_stream: one mode-0 8-bit MSB-first instance and one mode-3 16-bit LSB-first instance.
module tb_spi_target_stream;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        sclk0, cs0, mosi0, miso0, tx_valid0, tx_ready0, rx_valid0, rx_ready0;
  logic        rx_overrun0, tx_underrun0, frame_abort0, busy0;
  logic [7:0]  tx_data0, rx_data0;
  logic        sclk3, cs3, mosi3, miso3, tx_valid3, tx_ready3, rx_valid3, rx_ready3;
  logic        rx_overrun3, tx_underrun3, frame_abort3, busy3;
  logic [15:0] tx_data3, rx_data3;

  spi_target_stream dut0 (
    .clk(clk), .reset(reset), .sclk(sclk0), .cs(cs0), .mosi(mosi0), .miso(miso0),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0),
    .rx_overrun(rx_overrun0), .tx_underrun(tx_underrun0), .frame_abort(frame_abort0), .busy(busy0)
  );

  spi_target_stream #(.DATA_WIDTH(16), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) dut3 (
    .clk(clk), .reset(reset), .sclk(sclk3), .cs(cs3), .mosi(mosi3), .miso(miso3),
    .tx_data(tx_data3), .tx_valid(tx_valid3), .tx_ready(tx_ready3),
    .rx_data(rx_data3), .rx_valid(rx_valid3), .rx_ready(rx_ready3),
    .rx_overrun(rx_overrun3), .tx_underrun(tx_underrun3), .frame_abort(frame_abort3), .busy(busy3)
  );

  int total = 0;
  int bad   = 0;
  int ovr0 = 0, abt0 = 0, und3 = 0;
  logic [15:0] rx3_q[$];

  always @(negedge clk) begin
    if (rx_overrun0 === 1'b1) ovr0++;
    if (frame_abort0 === 1'b1) abt0++;
    if (tx_underrun3 === 1'b1) und3++;
    if (rx_valid3 === 1'b1 && rx_ready3 === 1'b1) rx3_q.push_back(rx_data3);
  end

  task automatic half();
    repeat (5) @(negedge clk);
  endtask

  task automatic wr0(input logic [7:0] d);
    @(negedge clk); tx_data0 = d; tx_valid0 = 1'b1;
    @(negedge clk); tx_valid0 = 1'b0;
  endtask

  task automatic wr3(input logic [15:0] d);
    @(negedge clk); tx_data3 = d; tx_valid3 = 1'b1;
    @(negedge clk); tx_valid3 = 1'b0;
  endtask

  task automatic frame0_begin();
    cs0 = 1'b0; half();
  endtask

  task automatic frame0_end();
    half(); cs0 = 1'b1; half(); half();
  endtask

  // Mode 0 master: drive mosi, raise sclk and sample miso; the last bit's high phase can pulse rx_ready.
  task automatic spi0_xfer(input logic [7:0] tx, input int nbits, input bit rdy_pulse,
                           output logic [7:0] rx, output int lat, output bit vlow);
    rx = '0; lat = 99; vlow = 1'b0;
    for (int b = 0; b < nbits; b++) begin
      mosi0 = tx[7-b];
      half();
      sclk0 = 1'b1;
      rx[7-b] = miso0;
      for (int k = 1; k <= 5; k++) begin
        @(negedge clk);
        if (b == nbits - 1) begin
          if (rx_valid0 === 1'b1 && lat == 99) lat = k;
          if (rdy_pulse && rx_valid0 !== 1'b1) vlow = 1'b1;
          if (rdy_pulse) rx_ready0 = (k == 2);
        end
      end
      sclk0 = 1'b0;
    end
  endtask

  // Mode 3 master, LSB first: falling edge shifts, rising edge samples.
  task automatic spi3_word(input logic [15:0] tx, output logic [15:0] rx);
    rx = '0;
    for (int b = 0; b < 16; b++) begin
      sclk3 = 1'b0; mosi3 = tx[b];
      half();
      sclk3 = 1'b1; rx[b] = miso3;
      half();
    end
  endtask

  task automatic consume0();
    @(negedge clk); rx_ready0 = 1'b1;
    @(negedge clk); rx_ready0 = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (miso0 !== 1'b0) begin bad++; $display("FAIL rst_miso got=%b want=0", miso0); end
    total++; if (rx_valid0 !== 1'b0) begin bad++; $display("FAIL rst_rx_valid got=%b want=0", rx_valid0); end
    total++; if (tx_ready0 !== 1'b1) begin bad++; $display("FAIL rst_tx_ready got=%b want=1", tx_ready0); end
    total++; if (rx_data0 !== 8'h00) begin bad++; $display("FAIL rst_rx_data got=%h want=00", rx_data0); end
    total++; if (tx_ready3 !== 1'b1) begin bad++; $display("FAIL rst_tx_ready3 got=%b want=1", tx_ready3); end
    reset = 1'b1;
    repeat (6) @(negedge clk);
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy0); end
    total++; if ({rx_overrun0, tx_underrun0, frame_abort0} !== 3'b000) begin
      bad++; $display("FAIL rst_pulses got=%b want=000", {rx_overrun0, tx_underrun0, frame_abort0}); end
    total++; if (miso3 !== 1'b0) begin bad++; $display("FAIL rst_miso3 got=%b want=0", miso3); end
  endtask

  task automatic test_mode0_basic();
    logic [7:0] rx; int lat; bit vl;
    wr0(8'h3C);
    total++; if (tx_ready0 !== 1'b0) begin bad++; $display("FAIL basic_hold_full got=%b want=0", tx_ready0); end
    frame0_begin();
    total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", busy0); end
    total++; if (tx_ready0 !== 1'b1) begin bad++; $display("FAIL basic_load_ready got=%b want=1", tx_ready0); end
    spi0_xfer(8'hA5, 8, 1'b0, rx, lat, vl);
    total++; if (lat > 4) begin bad++; $display("FAIL basic_latency got=%0d want<=4", lat); end
    total++; if (rx_data0 !== 8'hA5) begin bad++; $display("FAIL basic_rx_data got=%h want=a5", rx_data0); end
    total++; if (rx_valid0 !== 1'b1) begin bad++; $display("FAIL basic_rx_valid got=%b want=1", rx_valid0); end
    total++; if (rx !== 8'h3C) begin bad++; $display("FAIL basic_miso_word got=%h want=3c", rx); end
    frame0_end();
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%b want=0", busy0); end
    consume0();
    total++; if (rx_valid0 !== 1'b0) begin bad++; $display("FAIL basic_consume got=%b want=0", rx_valid0); end
  endtask

  task automatic test_mode3_burst();
    logic [15:0] r1, r2, r3;
    int base, u0;
    logic [15:0] exp_rx [3];
    exp_rx[0] = 16'h1234; exp_rx[1] = 16'hBEEF; exp_rx[2] = 16'h0001;
    rx_ready3 = 1'b1;
    base = rx3_q.size(); u0 = und3;
    wr3(16'hCAFE);
    cs3 = 1'b0; half();
    spi3_word(16'h1234, r1);
    fork
      spi3_word(16'hBEEF, r2);
      begin repeat (20) @(negedge clk); wr3(16'hA55A); end
    join
    spi3_word(16'h0001, r3);
    half(); cs3 = 1'b1; half(); half();
    total++; if (rx3_q.size() - base !== 3) begin
      bad++; $display("FAIL m3_rx_count got=%0d want=3", rx3_q.size() - base); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (base + i >= rx3_q.size() || rx3_q[base+i] !== exp_rx[i]) begin
        bad++; $display("FAIL m3_rx_word%0d got=%h want=%h", i,
                        (base + i < rx3_q.size()) ? rx3_q[base+i] : 16'hxxxx, exp_rx[i]);
      end
    end
    total++; if (r1 !== 16'hCAFE) begin bad++; $display("FAIL m3_miso_w1 got=%h want=cafe", r1); end
    total++; if (r2 !== 16'h0000) begin bad++; $display("FAIL m3_miso_w2 got=%h want=0000", r2); end
    total++; if (r3 !== 16'hA55A) begin bad++; $display("FAIL m3_miso_w3 got=%h want=a55a", r3); end
    total++; if (und3 - u0 !== 1) begin bad++; $display("FAIL m3_underrun got=%0d want=1", und3 - u0); end
  endtask

  task automatic test_overrun();
    logic [7:0] rx; int lat; bit vl; int o0;
    o0 = ovr0;
    frame0_begin();
    spi0_xfer(8'h11, 8, 1'b0, rx, lat, vl);
    spi0_xfer(8'h22, 8, 1'b0, rx, lat, vl);
    frame0_end();
    total++; if (rx_data0 !== 8'h11) begin bad++; $display("FAIL ovr_rx_data got=%h want=11", rx_data0); end
    total++; if (rx_valid0 !== 1'b1) begin bad++; $display("FAIL ovr_rx_valid got=%b want=1", rx_valid0); end
    total++; if (ovr0 - o0 !== 1) begin bad++; $display("FAIL ovr_pulses got=%0d want=1", ovr0 - o0); end
    consume0();
    total++; if (rx_valid0 !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b want=0", rx_valid0); end
  endtask

  task automatic test_abort();
    logic [7:0] rx; int lat; bit vl; int a0;
    a0 = abt0;
    frame0_begin();
    spi0_xfer(8'hFF, 5, 1'b0, rx, lat, vl);
    frame0_end();
    total++; if (abt0 - a0 !== 1) begin bad++; $display("FAIL abort_pulse got=%0d want=1", abt0 - a0); end
    total++; if (rx_valid0 !== 1'b0) begin bad++; $display("FAIL abort_no_valid got=%b want=0", rx_valid0); end
    frame0_begin();
    spi0_xfer(8'h7E, 8, 1'b0, rx, lat, vl);
    frame0_end();
    total++; if (rx_data0 !== 8'h7E) begin bad++; $display("FAIL abort_next_word got=%h want=7e", rx_data0); end
    total++; if (rx_valid0 !== 1'b1) begin bad++; $display("FAIL abort_next_valid got=%b want=1", rx_valid0); end
    total++; if (abt0 - a0 !== 1) begin bad++; $display("FAIL abort_clean_end got=%0d want=1", abt0 - a0); end
    consume0();
  endtask

  task automatic test_back_to_back();
    logic [7:0] rx; int lat; bit vl; int o0;
    o0 = ovr0;
    frame0_begin();
    spi0_xfer(8'h5A, 8, 1'b0, rx, lat, vl);
    frame0_end();
    total++; if (rx_valid0 !== 1'b1) begin bad++; $display("FAIL b2b_first_valid got=%b want=1", rx_valid0); end
    frame0_begin();
    spi0_xfer(8'h96, 8, 1'b1, rx, lat, vl);
    total++; if (rx_data0 !== 8'h96) begin bad++; $display("FAIL b2b_rx_data got=%h want=96", rx_data0); end
    total++; if (rx_valid0 !== 1'b1 || vl) begin
      bad++; $display("FAIL b2b_valid_held got=%b dropped=%b want=1/0", rx_valid0, vl); end
    frame0_end();
    total++; if (ovr0 - o0 !== 0) begin bad++; $display("FAIL b2b_no_overrun got=%0d want=0", ovr0 - o0); end
    consume0();
  endtask

  task automatic test_reset_midword();
    logic [7:0] rx; int lat; bit vl;
    frame0_begin();
    spi0_xfer(8'h81, 8, 1'b0, rx, lat, vl);
    frame0_end();
    wr0(8'hFF);
    frame0_begin();
    wr0(8'h0F);
    spi0_xfer(8'h00, 3, 1'b0, rx, lat, vl);
    total++; if ({miso0, tx_ready0, rx_valid0} !== 3'b101) begin
      bad++; $display("FAIL rmw_pre got=%b want=101", {miso0, tx_ready0, rx_valid0}); end
    @(negedge clk); reset = 1'b0; #1;
    total++; if (miso0 !== 1'b0) begin bad++; $display("FAIL rmw_miso got=%b want=0", miso0); end
    total++; if (rx_valid0 !== 1'b0) begin bad++; $display("FAIL rmw_rx_valid got=%b want=0", rx_valid0); end
    total++; if (tx_ready0 !== 1'b1) begin bad++; $display("FAIL rmw_tx_ready got=%b want=1", tx_ready0); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL rmw_busy got=%b want=0", busy0); end
    total++; if (rx_data0 !== 8'h00) begin bad++; $display("FAIL rmw_rx_data got=%h want=00", rx_data0); end
    cs0 = 1'b1; sclk0 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    frame0_begin();
    spi0_xfer(8'hC3, 8, 1'b0, rx, lat, vl);
    frame0_end();
    total++; if (rx_data0 !== 8'hC3) begin bad++; $display("FAIL rmw_fresh_word got=%h want=c3", rx_data0); end
    total++; if (rx_valid0 !== 1'b1) begin bad++; $display("FAIL rmw_fresh_valid got=%b want=1", rx_valid0); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    sclk0 = 1'b0; cs0 = 1'b1; mosi0 = 1'b0; tx_data0 = '0; tx_valid0 = 1'b0; rx_ready0 = 1'b0;
    sclk3 = 1'b1; cs3 = 1'b1; mosi3 = 1'b0; tx_data3 = '0; tx_valid3 = 1'b0; rx_ready3 = 1'b0;
    test_reset();
    test_mode0_basic();
    test_mode3_burst();
    test_overrun();
    test_abort();
    test_back_to_back();
    test_reset_midword();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
